// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
//   Two-approach intersection controller: NS is the main road, EW the side road.
//   Timed phases use a down-counter that loads T_x-1 on phase entry and exits at 0.
//   NS green holds after its minimum time until a side-road or pedestrian request.
//   All lamp outputs are registered and decoded from the next phase.
//   Optional pedestrian walk phase: define TRAFFIC_PED_WALK_EN to enable it.
//
//   phase        | meaning
//   -------------+-----------------------------------------------
//   0 NS_GREEN   | main road green, hold at count 0 until request
//   1 NS_YELLOW  | main road yellow
//   2 ALL_RED_1  | clearance before side road / walk
//   3 WALK       | pedestrian walk, both heads red
//   4 EW_GREEN   | side road green, fixed length
//   5 EW_YELLOW  | side road yellow
//   6 ALL_RED_2  | clearance before main road; reset phase
//   7            | illegal, recovers to ALL_RED_2

module traffic_intersection_ctrl #(
  parameter int CNT_W    = 8,
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  localparam logic [2:0] PH_NS_GREEN  = 3'd0;
  localparam logic [2:0] PH_NS_YELLOW = 3'd1;
  localparam logic [2:0] PH_ALL_RED_1 = 3'd2;
  localparam logic [2:0] PH_WALK      = 3'd3;
  localparam logic [2:0] PH_EW_GREEN  = 3'd4;
  localparam logic [2:0] PH_EW_YELLOW = 3'd5;
  localparam logic [2:0] PH_ALL_RED_2 = 3'd6;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Counter load values: a phase of T cycles starts at T-1 and exits at 0.
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Durations must be non-zero and their load value must fit the counter.
  if (T_GREEN < 1 || T_GREEN > 2**CNT_W) begin : g_bad_green
    $error("T_GREEN out of range for CNT_W");
  end
  if (T_YELLOW < 1 || T_YELLOW > 2**CNT_W) begin : g_bad_yellow
    $error("T_YELLOW out of range for CNT_W");
  end
  if (T_ALLRED < 1 || T_ALLRED > 2**CNT_W) begin : g_bad_allred
    $error("T_ALLRED out of range for CNT_W");
  end
  if (T_WALK < 1 || T_WALK > 2**CNT_W) begin : g_bad_walk
    $error("T_WALK out of range for CNT_W");
  end

  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_zero;
  logic             ped_q, ped_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  logic             walk_q, walk_d;
  logic             hold_release;

`ifdef TRAFFIC_PED_WALK_EN
  logic             walk_entry;
`else
  logic             unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  assign cnt_zero = (cnt_q == '0);

`ifdef TRAFFIC_PED_WALK_EN
  assign hold_release = ew_req | ped_q;
`else
  assign hold_release = ew_req;
`endif

  // State, counter, pedestrian latch and registered lamp outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_ALL_RED_2;
      cnt_q   <= LD_ALLRED;
      ped_q   <= 1'b0;
      ns_q    <= LAMP_RED;
      ew_q    <= LAMP_RED;
      walk_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      walk_q  <= walk_d;
    end
  end

  // Next phase and counter: decrement gated at 0, reload on every phase change.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_zero ? cnt_q : (cnt_q - CNT_ONE);
`ifdef TRAFFIC_PED_WALK_EN
    walk_entry = 1'b0;
`endif
    case (phase_q)
      PH_NS_GREEN: begin
        if (cnt_zero && hold_release) begin
          phase_d = PH_NS_YELLOW;
          cnt_d   = LD_YELLOW;
        end
      end
      PH_NS_YELLOW: begin
        if (cnt_zero) begin
          phase_d = PH_ALL_RED_1;
          cnt_d   = LD_ALLRED;
        end
      end
      PH_ALL_RED_1: begin
        if (cnt_zero) begin
`ifdef TRAFFIC_PED_WALK_EN
          if (ped_q) begin
            phase_d    = PH_WALK;
            cnt_d      = LD_WALK;
            walk_entry = 1'b1;
          end else begin
            phase_d = PH_EW_GREEN;
            cnt_d   = LD_GREEN;
          end
`else
          phase_d = PH_EW_GREEN;
          cnt_d   = LD_GREEN;
`endif
        end
      end
`ifdef TRAFFIC_PED_WALK_EN
      PH_WALK: begin
        if (cnt_zero) begin
          phase_d = PH_EW_GREEN;
          cnt_d   = LD_GREEN;
        end
      end
`endif
      PH_EW_GREEN: begin
        if (cnt_zero) begin
          phase_d = PH_EW_YELLOW;
          cnt_d   = LD_YELLOW;
        end
      end
      PH_EW_YELLOW: begin
        if (cnt_zero) begin
          phase_d = PH_ALL_RED_2;
          cnt_d   = LD_ALLRED;
        end
      end
      PH_ALL_RED_2: begin
        if (cnt_zero) begin
          phase_d = PH_NS_GREEN;
          cnt_d   = LD_GREEN;
        end
      end
      default: begin
        phase_d = PH_ALL_RED_2;
        cnt_d   = LD_ALLRED;
      end
    endcase
  end

  // Pedestrian latch: a press on the walk-entry cycle survives the clear.
`ifdef TRAFFIC_PED_WALK_EN
  assign ped_d = ped_req | (ped_q & ~walk_entry);
`else
  assign ped_d = 1'b0;
`endif

  // Lamp decode from the next phase so lamps change on the phase-change edge.
  always_comb begin
    ns_d   = LAMP_RED;
    ew_d   = LAMP_RED;
    walk_d = 1'b0;
    case (phase_d)
      PH_NS_GREEN:  ns_d = LAMP_GRN;
      PH_NS_YELLOW: ns_d = LAMP_YEL;
      PH_EW_GREEN:  ew_d = LAMP_GRN;
      PH_EW_YELLOW: ew_d = LAMP_YEL;
      default: begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
      end
    endcase
`ifdef TRAFFIC_PED_WALK_EN
    walk_d = (phase_d == PH_WALK);
`endif
  end

  assign phase       = phase_q;
  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl with default parameters.
// Expected phase/latch values are queued as stimulus is applied and popped per cycle.
module tb_traffic_intersection_ctrl;

  logic       clk;
  logic       rst;
  logic       ew_req;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] ph;
    logic       ped;
  } exp_t;

  exp_t sb_q[$];

  traffic_intersection_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ew_req      (ew_req),
    .ped_req     (ped_req),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .walk        (walk),
    .phase       (phase),
    .ped_pending (ped_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_ns(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(input logic [2:0] p);
    case (p)
      3'd4:    return 3'b001;
      3'd5:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [2:0] p, input int n, input logic ped);
    exp_t e;
    e.ph  = p;
    e.ped = ped;
    for (int i = 0; i < n; i++) sb_q.push_back(e);
  endtask

  // Leaves the bench one time unit after a rising edge with reset just released.
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_phase(input logic [2:0] p, input int max_cyc, input string tag);
    int n;
    n = 0;
    while (phase !== p && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (phase !== p) begin
      failures++;
      $display("FAIL %s: phase=%0d never reached required %0d within %0d cycles", tag, phase, p, max_cyc);
    end
  endtask

  task automatic test_reset();
    ew_req  = 1'b0;
    ped_req = 1'b0;
    rst     = 1'b0;
    #2 rst  = 1'b1;
    #1;
    checks++;
    if (phase !== 3'd6 || ns_light !== 3'b100 || ew_light !== 3'b100 ||
        walk !== 1'b0 || ped_pending !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: phase=%0d ns=%b ew=%b walk=%b pend=%b required 6 100 100 0 0",
               phase, ns_light, ew_light, walk, ped_pending);
    end
    step();
    step();
    checks++;
    if (phase !== 3'd6 || ns_light !== 3'b100 || ew_light !== 3'b100) begin
      failures++;
      $display("FAIL reset_held: phase=%0d ns=%b ew=%b required 6 100 100", phase, ns_light, ew_light);
    end
    rst = 1'b0;
  endtask

  // ew_req held high: two complete cycles with no hold and no walk.
  task automatic test_sequence();
    exp_t e;
    ew_req = 1'b1;
    do_reset();
    push_run(3'd6, 2, 1'b0);
    for (int r = 0; r < 2; r++) begin
      push_run(3'd0, 8, 1'b0);
      push_run(3'd1, 3, 1'b0);
      push_run(3'd2, 2, 1'b0);
      push_run(3'd4, 8, 1'b0);
      push_run(3'd5, 3, 1'b0);
      push_run(3'd6, 2, 1'b0);
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph || ns_light !== exp_ns(e.ph) || ew_light !== exp_ew(e.ph) || walk !== 1'b0) begin
        failures++;
        $display("FAIL sequence: phase=%0d ns=%b ew=%b walk=%b required %0d %b %b 0",
                 phase, ns_light, ew_light, walk, e.ph, exp_ns(e.ph), exp_ew(e.ph));
      end
      step();
    end
  endtask

  // No requests: NS green holds past its minimum, then exits one edge after ew_req.
  task automatic test_hold();
    exp_t e;
    ew_req  = 1'b0;
    ped_req = 1'b0;
    do_reset();
    wait_phase(3'd0, 20, "hold_enter");
    push_run(3'd0, 20, 1'b0);
    push_run(3'd1, 1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph || ns_light !== 3'b001) begin
        failures++;
        $display("FAIL hold_green: cycle %0d phase=%0d ns=%b required %0d 001", i, phase, ns_light, e.ph);
      end
      if (i == 20) ew_req = 1'b1;
      step();
    end
    e = sb_q.pop_front();
    checks++;
    if (phase !== e.ph || ns_light !== 3'b010 || ew_light !== 3'b100) begin
      failures++;
      $display("FAIL hold_exit: phase=%0d ns=%b ew=%b required %0d 010 100", phase, ns_light, ew_light, e.ph);
    end
  endtask

  // Reset during EW green at counter 4: immediate reset values, green 2 edges after release.
  task automatic test_reset_mid();
    exp_t e;
    ew_req  = 1'b1;
    ped_req = 1'b0;
    do_reset();
    wait_phase(3'd4, 40, "mid_enter_ew");
`ifdef TRAFFIC_PED_WALK_EN
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (ped_pending !== 1'b1) begin
      failures++;
      $display("FAIL mid_ped_set: pend=%b required 1", ped_pending);
    end
`else
    step();
`endif
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (phase !== 3'd6 || ns_light !== 3'b100 || ew_light !== 3'b100 ||
        ped_pending !== 1'b0 || walk !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: phase=%0d ns=%b ew=%b pend=%b walk=%b required 6 100 100 0 0",
               phase, ns_light, ew_light, ped_pending, walk);
    end
    #1 rst = 1'b0;
    push_run(3'd6, 2, 1'b0);
    push_run(3'd0, 1, 1'b0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph || ns_light !== exp_ns(e.ph) || ped_pending !== e.ped) begin
        failures++;
        $display("FAIL mid_recover: phase=%0d ns=%b pend=%b required %0d %b %b",
                 phase, ns_light, ped_pending, e.ph, exp_ns(e.ph), e.ped);
      end
      step();
    end
  endtask

`ifdef TRAFFIC_PED_WALK_EN
  // Pulse during EW green: NS green exits at minimum, then a 5-cycle walk.
  task automatic test_ped_walk();
    exp_t e;
    ew_req  = 1'b1;
    ped_req = 1'b0;
    do_reset();
    wait_phase(3'd4, 40, "ped_enter_ew");
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    ew_req  = 1'b0;
    checks++;
    if (ped_pending !== 1'b1) begin
      failures++;
      $display("FAIL ped_latch: pend=%b required 1", ped_pending);
    end
    wait_phase(3'd0, 40, "ped_enter_ns");
    push_run(3'd0, 8, 1'b1);
    push_run(3'd1, 3, 1'b1);
    push_run(3'd2, 2, 1'b1);
    push_run(3'd3, 5, 1'b0);
    push_run(3'd4, 1, 1'b0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (phase !== e.ph || ped_pending !== e.ped || walk !== (e.ph == 3'd3) ||
          ns_light !== exp_ns(e.ph) || ew_light !== exp_ew(e.ph)) begin
        failures++;
        $display("FAIL ped_walk: phase=%0d pend=%b walk=%b ns=%b ew=%b required %0d %b %b %b %b",
                 phase, ped_pending, walk, ns_light, ew_light, e.ph, e.ped, (e.ph == 3'd3),
                 exp_ns(e.ph), exp_ew(e.ph));
      end
      step();
    end
  endtask

  // Press on the exact ALL_RED_1 -> WALK edge is kept.
  task automatic test_ped_edge();
    ew_req  = 1'b1;
    ped_req = 1'b0;
    do_reset();
    wait_phase(3'd4, 40, "edge_enter_ew");
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    wait_phase(3'd2, 60, "edge_enter_ar1");
    step();
    checks++;
    if (phase !== 3'd2) begin
      failures++;
      $display("FAIL edge_ar1_len: phase=%0d required 2", phase);
    end
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    checks++;
    if (phase !== 3'd3 || ped_pending !== 1'b1 || walk !== 1'b1) begin
      failures++;
      $display("FAIL edge_set_wins: phase=%0d pend=%b walk=%b required 3 1 1", phase, ped_pending, walk);
    end
    step();
    checks++;
    if (ped_pending !== 1'b1) begin
      failures++;
      $display("FAIL edge_kept: pend=%b required 1", ped_pending);
    end
  endtask
`else
  // Pedestrian logic absent: button never releases the hold or lights walk.
  task automatic test_no_ped();
    ew_req  = 1'b0;
    ped_req = 1'b0;
    do_reset();
    wait_phase(3'd0, 20, "noped_enter");
    for (int i = 0; i < 40; i++) begin
      ped_req = (i % 2 == 0);
      step();
      checks++;
      if (phase !== 3'd0 || walk !== 1'b0 || ped_pending !== 1'b0) begin
        failures++;
        $display("FAIL no_ped: cycle %0d phase=%0d walk=%b pend=%b required 0 0 0",
                 i, phase, walk, ped_pending);
      end
    end
    ped_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_hold();
    test_reset_mid();
`ifdef TRAFFIC_PED_WALK_EN
    test_ped_walk();
    test_ped_edge();
`else
    test_no_ped();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
